// File: rtl/pop_count_pkg.sv
// Shared definitions for the popcount engine: FSM state encoding,
// an elaboration-time log2 helper and the per-stage mask builder.
package pop_count_pkg;

    // Widest word the mask builder can describe.
    localparam int MAX_WIDTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2, used for stage counts and index widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Mask for tree stage k: runs of 2^k ones followed by 2^k zeros,
    // starting at the LSB, limited to the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] stage_mask(input int width, input int stage);
        logic [MAX_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if ((i < width) && (((i >> stage) & 1) == 0)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/pop_count_stage.sv
// One level of the popcount reduction tree, selected by stage index.
// Every level is built in parallel and the index picks one, so the
// whole tree shares a single work register in the parent.
module pop_count_stage
    import pop_count_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int IDX_WIDTH  = 3
) (
    input  logic [DATA_WIDTH-1:0] i_work,
    input  logic [IDX_WIDTH-1:0]  i_stage,
    output logic [DATA_WIDTH-1:0] o_work
);

    localparam int STAGES = clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] stage_result [STAGES];

    // Each level adds neighbouring 2^k-bit fields into 2^(k+1)-bit fields;
    // field sums never exceed the field width, so no carries cross fields.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_level
            localparam logic [DATA_WIDTH-1:0] MASK = DATA_WIDTH'(stage_mask(DATA_WIDTH, gi));
            assign stage_result[gi] = (i_work & MASK) + ((i_work >> (1 << gi)) & MASK);
        end
    endgenerate

    // Select the level matching the current stage counter.
    always_comb begin
        o_work = stage_result[0];
        for (int k = 0; k < STAGES; k++) begin
            if (i_stage == IDX_WIDTH'(k)) begin
                o_work = stage_result[k];
            end
        end
    end

endmodule

// File: rtl/pop_count_engine.sv
// Iterative handshaked popcount engine with a saturating accumulator.
// A word is reduced one tree level per clock in a single work register;
// the low bits of that register are the result once the tree finishes.
module pop_count_engine
    import pop_count_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_WIDTH-1:0]       i_data_a,
    input  logic [DATA_WIDTH-1:0]       i_data_b,
    input  logic                        i_mode,
    input  logic                        i_accumulate,
    input  logic                        i_clear_acc,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [clog2(DATA_WIDTH):0]  o_count,
    output logic [ACC_WIDTH-1:0]        o_acc,
    output logic                        o_acc_sat
);

    localparam int STAGES    = clog2(DATA_WIDTH);
    localparam int CNT_WIDTH = STAGES + 1;
    localparam int IDX_WIDTH = (clog2(STAGES) < 1) ? 1 : clog2(STAGES);
    localparam int ACC_EXT   = ACC_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0] LAST_STAGE = IDX_WIDTH'(STAGES - 1);

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   stage_q, stage_d;
    logic [DATA_WIDTH-1:0]  work_q, work_d;
    logic                   acc_flag_q, acc_flag_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   acc_sat_q, acc_sat_d;
    logic                   o_ready_q, o_ready_d;
    logic                   o_valid_q, o_valid_d;

    logic [DATA_WIDTH-1:0]  stage_out;
    logic [CNT_WIDTH-1:0]   count;
    logic                   out_handshake;
    logic [ACC_WIDTH-1:0]   acc_base;
    logic                   sat_base;
    logic [ACC_WIDTH:0]     acc_sum;

    pop_count_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_stage (
        .i_work  (work_q),
        .i_stage (stage_q),
        .o_work  (stage_out)
    );

    assign count         = work_q[CNT_WIDTH-1:0];
    assign out_handshake = (state_q == ST_DONE) && i_ready;

    // FSM: accept in IDLE, one tree level per CALC cycle, hold in DONE.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        work_d     = work_q;
        acc_flag_d = acc_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    work_d     = i_mode ? i_data_a : (i_data_a ^ i_data_b);
                    acc_flag_d = i_accumulate;
                    stage_d    = '0;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                work_d  = stage_out;
                stage_d = stage_q + 1'b1;
                if (stage_q == LAST_STAGE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the next state.
        o_ready_d = (state_d == ST_IDLE);
        o_valid_d = (state_d == ST_DONE);
    end

    // Accumulator: clear is applied before any add in the same cycle;
    // an add that carries out of ACC_WIDTH pins the sum at all-ones.
    always_comb begin
        acc_base  = i_clear_acc ? '0 : acc_q;
        sat_base  = i_clear_acc ? 1'b0 : acc_sat_q;
        acc_sum   = {1'b0, acc_base} + ACC_EXT'(count);
        acc_d     = acc_base;
        acc_sat_d = sat_base;
        if (out_handshake && acc_flag_q) begin
            if (acc_sum[ACC_WIDTH]) begin
                acc_d     = '1;
                acc_sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_WIDTH-1:0];
            end
        end
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            work_q     <= '0;
            acc_flag_q <= 1'b0;
            acc_q      <= '0;
            acc_sat_q  <= 1'b0;
            o_ready_q  <= 1'b1;
            o_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            work_q     <= work_d;
            acc_flag_q <= acc_flag_d;
            acc_q      <= acc_d;
            acc_sat_q  <= acc_sat_d;
            o_ready_q  <= o_ready_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign o_ready   = o_ready_q;
    assign o_valid   = o_valid_q;
    assign o_count   = count;
    assign o_acc     = acc_q;
    assign o_acc_sat = acc_sat_q;

endmodule

// File: tb/tb_pop_count_engine.sv
// Directed bench for pop_count_engine. Two instances share the inputs:
// a 32-bit accumulator and an 8-bit one to reach saturation quickly.
module tb_pop_count_engine;

    localparam int DW     = 128;
    localparam int STAGES = 7;
    localparam int NUM    = 1500;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_valid;
    logic [DW-1:0] i_data_a;
    logic [DW-1:0] i_data_b;
    logic         i_mode;
    logic         i_accumulate;
    logic         i_clear_acc;
    logic         i_ready;

    logic         o_ready, o_valid, o_acc_sat;
    logic [7:0]   o_count;
    logic [31:0]  o_acc;
    logic         s_ready, s_valid, s_acc_sat;
    logic [7:0]   s_count;
    logic [7:0]   s_acc;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    pop_count_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_mode(i_mode),
        .i_accumulate(i_accumulate), .i_clear_acc(i_clear_acc),
        .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
        .o_acc(o_acc), .o_acc_sat(o_acc_sat)
    );

    pop_count_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(8)) dut_s (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(s_ready),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_mode(i_mode),
        .i_accumulate(i_accumulate), .i_clear_acc(i_clear_acc),
        .o_valid(s_valid), .i_ready(i_ready), .o_count(s_count),
        .o_acc(s_acc), .o_acc_sat(s_acc_sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ones(input int n);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int popc(input logic [DW-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < DW; i++) n += int'(v[i]);
        return n;
    endfunction

    // Present one word for one accepting edge, then scramble the inputs
    // so that anything sampled outside the accept cycle would show up.
    task automatic accept_word(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic mode, input logic accum);
        int g;
        g = 0;
        while (!o_ready && g < 40) begin
            tick();
            g++;
        end
        chk("accept_ready", o_ready, 1);
        chk("accept_ready_small", s_ready, 1);
        i_data_a     = a;
        i_data_b     = b;
        i_mode       = mode;
        i_accumulate = accum;
        i_valid      = 1'b1;
        tick();
        i_valid      = 1'b0;
        i_data_a     = ~a;
        i_data_b     = a ^ {DW{1'b1}};
        i_mode       = ~mode;
        i_accumulate = ~accum;
    endtask

    // lat counts cycles: cycle 1 is the one right after the accept edge.
    task automatic wait_result(output logic [7:0] cnt, output int lat);
        lat = 1;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("result_valid", o_valid, 1);
        chk("result_valid_small", s_valid, 1);
        cnt = o_count;
    endtask

    task automatic release_result(input logic clr);
        i_ready     = 1'b1;
        i_clear_acc = clr;
        tick();
        i_ready     = 1'b0;
        i_clear_acc = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]    cnt;
        int            lat;
        logic [DW-1:0] pat;
        logic [DW-1:0] ra, rb;
        logic          rm;
        int            exp_q[$];
        int            accepted, results, last_acc, expv;

        i_reset = 1'b1; i_valid = 1'b0; i_data_a = '0; i_data_b = '0;
        i_mode = 1'b0; i_accumulate = 1'b0; i_clear_acc = 1'b0; i_ready = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;

        // Reset state
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_acc", o_acc, 0);
        chk("rst_sat", o_acc_sat, 0);

        // All-ones XOR zero: full count, valid in cycle STAGES+1
        accept_word({DW{1'b1}}, '0, 1'b0, 1'b0);
        wait_result(cnt, lat);
        chk("ones_count", cnt, 128);
        chk("ones_latency", lat, STAGES + 1);
        release_result(1'b0);

        // Equal words XOR to zero; mode 1 counts A alone (0xDEADBEEF has 24 ones)
        pat = {4{32'hDEADBEEF}};
        accept_word(pat, pat, 1'b0, 1'b0);
        wait_result(cnt, lat);
        chk("equal_xor", cnt, 0);
        release_result(1'b0);
        accept_word(pat, ~pat, 1'b1, 1'b0);
        wait_result(cnt, lat);
        chk("mode_a_only", cnt, 96);
        release_result(1'b0);
        accept_word(pat, ~pat, 1'b0, 1'b0);
        wait_result(cnt, lat);
        chk("complement_xor", cnt, 128);
        release_result(1'b0);

        // Back-pressure: 20 stalled cycles with a competing valid word
        accept_word({16{8'h0F}}, '0, 1'b0, 1'b0);
        wait_result(cnt, lat);
        i_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("stall_count", o_count, 64);
            chk("stall_ready", o_ready, 0);
            chk("stall_valid", o_valid, 1);
            tick();
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        i_valid = 1'b0;
        chk("post_hs_valid", o_valid, 0);
        chk("post_hs_ready", o_ready, 1);
        tick();
        chk("single_hs", o_valid, 0);

        // Reset in the 3rd CALC cycle discards the word and the accumulator
        accept_word(ones(5), '0, 1'b0, 1'b1);
        wait_result(cnt, lat);
        release_result(1'b0);
        chk("pre_reset_acc", o_acc, 5);
        accept_word({DW{1'b1}}, '0, 1'b0, 1'b1);
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("midcalc_valid", o_valid, 0);
        chk("midcalc_ready", o_ready, 1);
        chk("midcalc_acc", o_acc, 0);
        chk("midcalc_count", o_count, 0);
        accept_word({{(DW-1){1'b0}}, 1'b1}, '0, 1'b0, 1'b0);
        wait_result(cnt, lat);
        chk("after_reset_count", cnt, 1);
        release_result(1'b0);

        // Ten accumulated counts of 100; 8-bit accumulator saturates on the 3rd
        for (int k = 0; k < 10; k++) begin
            accept_word(ones(100), '0, 1'b0, 1'b1);
            wait_result(cnt, lat);
            release_result(1'b0);
            chk("acc32_sum", o_acc, 100 * (k + 1));
            chk("acc8_sum", s_acc, (k == 0) ? 100 : ((k == 1) ? 200 : 255));
            chk("acc8_sat", s_acc_sat, (k >= 2) ? 1 : 0);
        end
        i_clear_acc = 1'b1;
        tick();
        i_clear_acc = 1'b0;
        chk("clear_acc8", s_acc, 0);
        chk("clear_sat8", s_acc_sat, 0);
        chk("clear_acc32", o_acc, 0);

        // Build acc=500, then clear coincident with an accumulate of 37
        for (int k = 0; k < 4; k++) begin
            accept_word(ones((k == 3) ? 116 : 128), '0, 1'b0, 1'b1);
            wait_result(cnt, lat);
            release_result(1'b0);
        end
        chk("acc_500", o_acc, 500);
        chk("acc8_sat_again", s_acc_sat, 1);
        accept_word(ones(37), '0, 1'b0, 1'b1);
        wait_result(cnt, lat);
        chk("count_37", cnt, 37);
        release_result(1'b1);
        chk("clear_add_acc32", o_acc, 37);
        chk("clear_add_sat32", o_acc_sat, 0);
        chk("clear_add_acc8", s_acc, 37);
        chk("clear_add_sat8", s_acc_sat, 0);

        // Random words, i_valid and i_ready held high: back-to-back stream
        accepted = 0;
        results  = 0;
        last_acc = -1;
        i_ready  = 1'b1;
        for (int cyc = 0; cyc < NUM * (STAGES + 2) + 100 && results < NUM; cyc++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rm = 1'($urandom_range(0, 1));
            i_data_a = ra;
            i_data_b = rb;
            i_mode   = rm;
            i_accumulate = 1'b0;
            i_valid  = (accepted < NUM);
            if (o_valid) begin
                chk("rand_pending", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    expv = exp_q.pop_front();
                    chk("rand_count", o_count, expv);
                    chk("rand_count_small", s_count, expv);
                end
                results++;
            end
            if (o_ready && i_valid) begin
                chk("rand_idle_only", exp_q.size(), 0);
                if (last_acc >= 0) chk("rand_interval", cyc - last_acc, STAGES + 2);
                last_acc = cyc;
                exp_q.push_back(rm ? popc(ra) : popc(ra ^ rb));
                accepted++;
            end
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("rand_results", results, NUM);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
